// File: rtl/stencil_pkg.sv
// Shared helpers for the stencil line buffer: counter widths and the
// (row, column) -> bit-offset mapping of the flattened window bus.
package stencil_pkg;

  // Default geometry (matches the top-level parameter defaults).
  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;

  // Counter widths for the default geometry.
  localparam int unsigned DEF_COL_W = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_ROW_W = $clog2(DEF_IMG_H);

  // Width of a counter that must hold 0..n-1. At least one bit so a
  // degenerate 1-wide or 1-high image still gets a legal vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of window element (r, c) in the flattened window bus.
  // Row 0 is the oldest line, column 0 is the oldest pixel.
  function automatic int unsigned win_off(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned stencil_w,
                                          input int unsigned data_w);
    return (r * stencil_w + c) * data_w;
  endfunction

endpackage

// File: rtl/lb_row_fifo.sv
// One line of pixel storage, used as a ring indexed by the column counter.
// The read port is combinational and always returns the value stored
// before this edge's write, so a pixel from the previous line can be
// passed down the chain on the same edge that overwrites it.
module lb_row_fifo #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Old contents at the shared address feed the next stage.
  assign rdata = mem_q[addr];

  // Write the accepted pixel into the slot just read.
  // NOTE: storage arrays carry no reset; clearing them would force
  // flop-based memory and nothing downstream trusts their contents
  // until a full line has been rewritten.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/stencil_line_buffer.sv
// Streaming line buffer: turns a raster pixel stream into a
// STENCIL_H x STENCIL_W window per accepted pixel, with valid and
// end-of-frame qualifiers.
// Optional feature: define STENCIL_LB_OUT_REG_EN to add one extra output
// register stage (latency 2 instead of 1).
module stencil_line_buffer
  import stencil_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 64,
  parameter int unsigned STENCIL_W = 3,
  parameter int unsigned STENCIL_H = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [DATA_W-1:0]                     in_data,
  output logic                                  out_valid,
  output logic [STENCIL_H*STENCIL_W*DATA_W-1:0] out_stencil,
  output logic                                  out_last
);

  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam int unsigned ROW_W = cnt_w(IMG_H);
  localparam int unsigned OUT_W = STENCIL_H * STENCIL_W * DATA_W;

  typedef logic [STENCIL_H-1:0][STENCIL_W-1:0][DATA_W-1:0] win_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_at_end, row_at_end;
  logic             col_ok, row_ok;
  logic             accept;

  // Pixel entering each window row this cycle: row STENCIL_H-1 is the
  // live input, older rows come out of the line memory chain.
  logic [STENCIL_H-1:0][DATA_W-1:0] row_in;

  win_t taps_q, taps_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q,  out_last_d;

  // Reset dominates; memory writes are suppressed during reset as well.
  assign accept     = in_valid & ~rst;

  assign col_at_end = (col_q == COL_W'(IMG_W - 1));
  assign row_at_end = (row_q == ROW_W'(IMG_H - 1));

  // Signed compares keep the 1-wide / 1-high stencil cases free of
  // always-true unsigned comparisons.
  assign col_ok     = (int'(col_q) >= int'(STENCIL_W) - 1);
  assign row_ok     = (int'(row_q) >= int'(STENCIL_H) - 1);

  assign row_in[STENCIL_H-1] = in_data;

  // Line memory: STENCIL_H-1 chained row stores sharing the column address.
  if (STENCIL_H > 1) begin : g_line_mem
    logic [DATA_W-1:0] fifo_rd [STENCIL_H-1];

    for (genvar k = 0; k < STENCIL_H - 1; k++) begin : g_fifo
      logic [DATA_W-1:0] fifo_wr;

      if (k == 0) begin : g_head
        assign fifo_wr = in_data;
      end else begin : g_link
        assign fifo_wr = fifo_rd[k-1];
      end

      lb_row_fifo #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
      ) u_row_fifo (
        .clk   (clk),
        .en    (accept),
        .addr  (col_q),
        .wdata (fifo_wr),
        .rdata (fifo_rd[k])
      );

      assign row_in[STENCIL_H-2-k] = fifo_rd[k];
    end
  end

  // Raster position of the pixel being accepted, wrapping line then frame.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_at_end) begin
        col_d = '0;
        row_d = row_at_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Horizontal taps: each window row shifts left by one on accept and
  // takes its new pixel in the newest column.
  always_comb begin
    taps_d = taps_q;
    if (in_valid) begin
      for (int r = 0; r < int'(STENCIL_H); r++) begin
        for (int c = 0; c < int'(STENCIL_W) - 1; c++) begin
          taps_d[r][c] = taps_q[r][c+1];
        end
        taps_d[r][STENCIL_W-1] = row_in[r];
      end
    end
  end

  // Window qualifiers for the pixel being accepted; an idle cycle drops them.
  always_comb begin
    out_valid_d = in_valid & col_ok & row_ok;
    out_last_d  = in_valid & col_at_end & row_at_end;
  end

  // Position counters, taps and qualifiers; synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      taps_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      taps_q      <= taps_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef STENCIL_LB_OUT_REG_EN
  win_t oreg_stencil_q, oreg_stencil_d;
  logic oreg_valid_q,   oreg_valid_d;
  logic oreg_last_q,    oreg_last_d;

  // Extra output stage simply follows the window registers.
  always_comb begin
    oreg_stencil_d = taps_q;
    oreg_valid_d   = out_valid_q;
    oreg_last_d    = out_last_q;
  end

  // Extra output stage, cleared by reset like the first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      oreg_stencil_q <= '0;
      oreg_valid_q   <= 1'b0;
      oreg_last_q    <= 1'b0;
    end else begin
      oreg_stencil_q <= oreg_stencil_d;
      oreg_valid_q   <= oreg_valid_d;
      oreg_last_q    <= oreg_last_d;
    end
  end

  win_t out_win;
  assign out_win   = oreg_stencil_q;
  assign out_valid = oreg_valid_q;
  assign out_last  = oreg_last_q;
`else
  win_t out_win;
  assign out_win   = taps_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
`endif

  // Flatten the window onto the output bus using the shared index mapping.
  logic [OUT_W-1:0] stencil_flat;
  always_comb begin
    stencil_flat = '0;
    for (int r = 0; r < int'(STENCIL_H); r++) begin
      for (int c = 0; c < int'(STENCIL_W); c++) begin
        stencil_flat[win_off(r, c, STENCIL_W, DATA_W) +: DATA_W] = out_win[r][c];
      end
    end
  end

  assign out_stencil = stencil_flat;

endmodule

// File: tb/tb_stencil_line_buffer.sv
// Self-checking bench: a 4x4 image through a 2x2 and a 1x2 line buffer fed
// by the same stream, compared against a frame-array reference model.
module tb_stencil_line_buffer;

`ifdef STENCIL_LB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        v;
    logic        l;
    logic [31:0] s;
    logic        h1v;
    logic        h1l;
    logic [15:0] h1s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        v2, l2, v1, l1;
  logic [31:0] s2;
  logic [15:0] s1;

  int          checks   = 0;
  int          failures = 0;

  logic [7:0]  img [4][4];
  int          mrow, mcol;
  exp_t        pipe [2];
  logic [31:0] win_q [$];
  int          win1_cnt;

  always #5 clk = ~clk;

  stencil_line_buffer #(
    .DATA_W(8), .IMG_W(4), .IMG_H(4), .STENCIL_W(2), .STENCIL_H(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2), .out_stencil(s2), .out_last(l2)
  );

  stencil_line_buffer #(
    .DATA_W(8), .IMG_W(4), .IMG_H(4), .STENCIL_W(2), .STENCIL_H(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_stencil(s1), .out_last(l1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window ending at frame position (r, c) for an h x w stencil.
  function automatic logic [31:0] ref_win(input int h, input int w, input int r, input int c);
    logic [31:0] res = '0;
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++)
        res[(i*w+j)*8 +: 8] = img[r-h+1+i][c-w+1+j];
    return res;
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    exp_t        e;
    logic [31:0] t;
    e = '0;
    in_valid = v;
    in_data  = d;
    if (v) begin
      img[mrow][mcol] = d;
      if (mcol >= 1 && mrow >= 1) begin
        e.v = 1'b1;
        e.s = ref_win(2, 2, mrow, mcol);
        e.l = (mrow == 3 && mcol == 3);
      end
      if (mcol >= 1) begin
        t     = ref_win(1, 2, mrow, mcol);
        e.h1v = 1'b1;
        e.h1s = t[15:0];
        e.h1l = (mrow == 3 && mcol == 3);
      end
      if (mcol == 3) begin
        mcol = 0;
        mrow = (mrow == 3) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end
    pipe[1] = pipe[0];
    pipe[0] = e;
    @(posedge clk);
    #1;
    check("valid_2x2", v2, pipe[LAT-1].v);
    check("last_2x2",  l2, pipe[LAT-1].l);
    if (pipe[LAT-1].v) check("win_2x2", s2, pipe[LAT-1].s);
    check("valid_1x2", v1, pipe[LAT-1].h1v);
    check("last_1x2",  l1, pipe[LAT-1].h1l);
    if (pipe[LAT-1].h1v) check("win_1x2", s1, pipe[LAT-1].h1s);
    if (v2) win_q.push_back(s2);
    if (v1) win1_cnt++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    pipe[0]  = '0;
    pipe[1]  = '0;
    mrow     = 0;
    mcol     = 0;
    @(posedge clk);
    #1;
    check("rst_valid_2x2", v2, 1'b0);
    check("rst_last_2x2",  l2, 1'b0);
    check("rst_win_2x2",   s2, 32'h0);
    check("rst_valid_1x2", v1, 1'b0);
    check("rst_win_1x2",   s1, 16'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic ramp_checks(input string tag);
    check({tag, "_count_2x2"}, win_q.size(), 9);
    check({tag, "_count_1x2"}, win1_cnt, 12);
    check({tag, "_first"}, win_q[0], 32'h05040100);
    check({tag, "_final"}, win_q[win_q.size()-1], 32'h0F0E0B0A);
  endtask

  initial begin
    int   acc;
    int   guard;
    logic v;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    do_reset();

    // Continuous ramp frame.
    win_q.delete(); win1_cnt = 0;
    for (int p = 0; p < 16; p++) step(1'b1, 8'(p));
    step(1'b0, 8'h0); step(1'b0, 8'h0);
    ramp_checks("ramp");

    // Ramp with in_valid alternating.
    win_q.delete(); win1_cnt = 0;
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 8'(p));
      step(1'b0, 8'h0);
    end
    step(1'b0, 8'h0);
    ramp_checks("alt");

    // Two back-to-back frames, the second offset by 100.
    win_q.delete(); win1_cnt = 0;
    for (int p = 0; p < 16; p++) step(1'b1, 8'(p));
    for (int p = 0; p < 16; p++) step(1'b1, 8'(p + 100));
    step(1'b0, 8'h0); step(1'b0, 8'h0);
    check("b2b_count", win_q.size(), 18);
    check("b2b_f2_first", win_q[9], 32'h69686564);

    // Reset mid-frame after 6 accepts, then a fresh ramp.
    for (int p = 0; p < 6; p++) step(1'b1, 8'(p + 50));
    do_reset();
    win_q.delete(); win1_cnt = 0;
    for (int p = 0; p < 16; p++) step(1'b1, 8'(p));
    step(1'b0, 8'h0); step(1'b0, 8'h0);
    ramp_checks("post_rst");

    // Random data with random idle cycles.
    for (int f = 0; f < 3; f++) begin
      win_q.delete(); win1_cnt = 0;
      acc = 0; guard = 0;
      while (acc < 16 && guard < 1000) begin
        v = ($urandom_range(0, 3) != 0);
        step(v, 8'($urandom_range(0, 255)));
        if (v) acc++;
        guard++;
      end
      step(1'b0, 8'h0); step(1'b0, 8'h0);
      check("rand_count_2x2", win_q.size(), 9);
      check("rand_count_1x2", win1_cnt, 12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
